// File: rtl/alu_exec_responder_if.sv
// +-----------------------------------------------------------------------------
// | alu_exec_responder_if : request/response bundle of the ALU responder
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

interface alu_exec_responder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, carry, zero
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, carry, zero
    );
endinterface

`default_nettype wire

// File: rtl/alu_exec_responder.sv
// +-----------------------------------------------------------------------------
// | alu_exec_responder : one-stage ALU feeding an in-order FWFT result buffer
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module alu_exec_responder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    alu_exec_responder_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = WIDTH + 2;
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    localparam logic [2:0] c_op_add = 3'd0;
    localparam logic [2:0] c_op_sub = 3'd1;
    localparam logic [2:0] c_op_and = 3'd2;
    localparam logic [2:0] c_op_or  = 3'd3;
    localparam logic [2:0] c_op_xor = 3'd4;
    localparam logic [2:0] c_op_shl = 3'd5;
    localparam logic [2:0] c_op_shr = 3'd6;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic [EW-1:0]    r_mem [DEPTH];

    logic [CW-1:0]    w_occ;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_out_valid;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_zero;
    logic [EW-1:0]    w_head;

    // Readiness looks only at registered occupancy, so a same-cycle pop never
    // opens a slot early and the buffer cannot overflow.
    assign w_occ       = r_count + {{PW{1'b0}}, r_s1_valid};
    assign bus.in_ready = (w_occ < c_depth);
    assign w_accept    = bus.in_valid && bus.in_ready;
    assign w_push      = r_s1_valid;
    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid && bus.out_ready;

    always_comb begin
        w_sum   = {1'b0, r_a} + {1'b0, r_b};
        w_diff  = {1'b0, r_a} - {1'b0, r_b};
        w_res   = '0;
        w_carry = 1'b0;
        case (r_op)
            c_op_add: begin w_res = w_sum[WIDTH-1:0];  w_carry = w_sum[WIDTH];  end
            c_op_sub: begin w_res = w_diff[WIDTH-1:0]; w_carry = w_diff[WIDTH]; end
            c_op_and: w_res = r_a & r_b;
            c_op_or:  w_res = r_a | r_b;
            c_op_xor: w_res = r_a ^ r_b;
            c_op_shl: begin w_res = {r_a[WIDTH-2:0], 1'b0}; w_carry = r_a[WIDTH-1]; end
            c_op_shr: begin w_res = {1'b0, r_a[WIDTH-1:1]}; w_carry = r_a[0];       end
            default:  w_res = r_b;
        endcase
        w_zero = (w_res == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
        end else begin
            // Stage 1 always drains into the buffer on the following edge.
            r_s1_valid <= w_accept;
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a  <= bus.a;
            r_b  <= bus.b;
            r_op <= bus.op;
        end
        if (w_push) r_mem[r_wr] <= {w_res, w_carry, w_zero};
    end

    assign w_head        = r_mem[r_rd];
    assign bus.out_valid = w_out_valid;
    assign bus.result    = w_out_valid ? w_head[EW-1:2] : '0;
    assign bus.carry     = w_out_valid ? w_head[1] : 1'b0;
    assign bus.zero      = w_out_valid ? w_head[0] : 1'b0;
endmodule

`default_nettype wire

// File: doc/alu_exec_responder.md
# alu_exec_responder

Execution-side responder for the ALU stimulus interface. It accepts operand/opcode requests over a valid/ready handshake, computes through one registered stage, and queues results with flags in an in-order output buffer that drains under consumer backpressure. It sits behind the ALU interface as the DUT end, opposite the environment's driver and monitor.

## Interface

Parameters:
- WIDTH, 8, operand and result width in bits
- DEPTH, 4, result buffer entries (power of two, ≥2)

Ports:
- clk  input  1  single clock, all state updates on its rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on the clk rising edge
- in_valid  input  1  request valid
- in_ready  output  1  responder can accept a request this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  3  opcode
- out_valid  output  1  buffer head holds a result
- out_ready  input  1  consumer takes head this cycle
- result  output  WIDTH  head result
- carry  output  1  head carry/borrow/shift-out flag
- zero  output  1  head result == 0

## Operation

- Request accepted on an edge where in_valid && in_ready; a, b, op captured into stage-1 register, s1_valid set.
- Stage 1 computes combinationally from registered operands; the next edge writes {result, carry, zero} into the buffer tail and clears s1_valid, unless a new request is accepted on that edge.
- Opcodes (all arithmetic mod 2^WIDTH):
  - 0 ADD: a+b; carry = bit WIDTH of the (WIDTH+1)-bit sum
  - 1 SUB: a−b; carry = borrow (a < b, unsigned)
  - 2 AND, 3 OR, 4 XOR: carry = 0
  - 5 SHL: a<<1, LSB 0; carry = a[WIDTH−1]
  - 6 SHR: a>>1 logical; carry = a[0]
  - 7 PASSB: result = b; carry = 0
- zero = (result == 0), computed on the result written.
- Buffer: DEPTH-entry FIFO, first-word-fall-through; out_valid = (count != 0); result/carry/zero show the head entry. Pop on out_valid && out_ready.
- Pointers wrap modulo DEPTH; count is 0..DEPTH.
- in_ready = (count + s1_valid) < DEPTH, derived from registered state only. A same-cycle pop does not raise in_ready in that cycle. The buffer can never overflow.
- Simultaneous push and pop: count unchanged; if count==1 the popped entry is replaced by the pushed one, with no bubble beyond the normal latency.
- Results leave strictly in acceptance order.

## Timing

- Reset (rst_n low at an edge): s1_valid=0, count=0, pointers=0. Outputs after that edge: in_ready=1, out_valid=0, result=0, carry=0, zero=0. Buffer contents need not be cleared, but outputs are forced to 0 when out_valid=0.
- Reset mid-operation discards the in-flight stage-1 request and all buffered results. No partial output appears after the reset edge.
- Latency: request accepted at edge N gives out_valid=1 with its result from edge N+1 if the buffer is empty.
- Throughput: with out_ready held 1, one request per cycle is sustained. count stays ≤1, so in_ready stays 1.
- A popped head is replaced by the next entry from the following edge.
- out_valid and the head data stay stable while out_valid && !out_ready.

## Test plan

- Reset: hold rst_n=0 for 3 edges with in_valid=1 → in_ready=1, out_valid=0, result=0 after release; nothing is ever output for requests presented during reset.
- ADD/SUB flags: ADD a=8'hF0, b=8'h20 → result 8'h10, carry 1, zero 0. SUB 8'h05−8'h05 → 8'h00, carry 0, zero 1. SUB 8'h03−8'h05 → 8'hFE, carry 1. Each is out_valid one edge after acceptance.
- Shifts/logic/pass: SHL 8'h81 → 8'h02, carry 1. SHR 8'h81 → 8'h40, carry 1. AND 8'hF0&8'h0F → 8'h00, zero 1. XOR 8'hAA^8'hFF → 8'h55. PASSB b=8'h3C → 8'h3C, carry 0.
- Backpressure: out_ready=0, issue 6 back-to-back ADDs with a=1..6, b=0 → exactly 4 accepted and in_ready=0 after the 4th. Then raise out_ready → results 1,2,3,4 in order, in_ready returns to 1, and the remaining requests then complete as 5,6.
- Streaming: out_ready=1, in_valid=1 for 16 cycles with a=i, b=1, op=ADD → 16 results i+1 on consecutive cycles, in_ready never drops, and the a=8'hFF-style wrap case gives 8'h00 with carry 1.
- Reset mid-flight: buffer 3 results with out_ready=0, pulse rst_n low for one edge → out_valid=0 next cycle, count=0, and the old results never appear.
